// File: rtl/fact_param_if.sv
// Handshake and data bundle for the fact_param multi-cycle factorial unit.
// Ports: n/go from the requester; factorial_out/busy/done/err back to it.
interface fact_param_if #(
    parameter int N_WIDTH   = 8,
    parameter int OUT_WIDTH = 32
);
    logic [N_WIDTH-1:0]   n;
    logic                 go;
    logic [OUT_WIDTH-1:0] factorial_out;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output n,
        output go,
        input  factorial_out,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  n,
        input  go,
        output factorial_out,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/fact_param.sv
// Sequential factorial unit: n! by descending multiply, overflow-checked.
// Ports: clk, rst (async active-low), bus (fact_param_if.slave: n, go in;
// factorial_out, busy, done, err out; all outputs registered/state-decoded).
module fact_param #(
    parameter int N_WIDTH   = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    fact_param_if.slave  bus
);
    localparam int PW = OUT_WIDTH + N_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [N_WIDTH-1:0]   cnt;
    logic [OUT_WIDTH-1:0] prod;
    logic [OUT_WIDTH-1:0] fact_q;
    logic [PW-1:0]        p;
    logic                 ovf;
    logic                 last;
    logic                 start;

    // Full-width product so that any overflow bit is visible.
    always_comb begin
        p    = {{N_WIDTH{1'b0}}, prod} * {{OUT_WIDTH{1'b0}}, cnt};
        ovf  = |p[PW-1:OUT_WIDTH];
        last = (cnt <= N_WIDTH'(1));
        // go is only honoured outside BUSY
        start = bus.go && (state != BUSY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (bus.go) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_nxt = DONE;
                end else if (ovf) begin
                    state_nxt = ERR;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            prod   <= '0;
            fact_q <= '0;
        end else if (start) begin
            // factorial_out keeps its old value until the next completion
            cnt  <= bus.n;
            prod <= OUT_WIDTH'(1);
        end else if (state == BUSY) begin
            unique case (1'b1)
                last: begin
                    fact_q <= prod;
                end
                !last && ovf: begin
                    fact_q <= '0;
                end
                !last && !ovf: begin
                    prod <= p[OUT_WIDTH-1:0];
                    cnt  <= cnt - N_WIDTH'(1);
                end
            endcase
        end
    end

    always_comb begin
        bus.busy          = (state == BUSY);
        bus.done          = (state == DONE) || (state == ERR);
        bus.err           = (state == ERR);
        bus.factorial_out = fact_q;
    end
endmodule

// File: tb/tb_fact_param.sv
// Directed self-checking bench for fact_param (32-bit and 64-bit results).
// Ports: drives both instances through fact_param_if master-side signals.
module tb_fact_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fact_param_if #(.N_WIDTH(8), .OUT_WIDTH(32)) b32 ();
    fact_param_if #(.N_WIDTH(8), .OUT_WIDTH(64)) b64 ();

    fact_param #(.N_WIDTH(8), .OUT_WIDTH(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    fact_param #(.N_WIDTH(8), .OUT_WIDTH(64)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (b64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start edge is the first tick; returns with go low, just after it.
    task automatic start32(input logic [7:0] nv);
        b32.n  = nv;
        b32.go = 1'b1;
        tick();
        b32.go = 1'b0;
        b32.n  = 8'hA5;
    endtask

    task automatic start64(input logic [7:0] nv);
        b64.n  = nv;
        b64.go = 1'b1;
        tick();
        b64.go = 1'b0;
        b64.n  = 8'h5A;
    endtask

    // Counts edges after the start edge until done; bounded.
    task automatic wait32(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (b32.done !== 1'b1 && lat < 400) begin
            if (b32.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic wait64(output int lat);
        lat = 0;
        while (b64.done !== 1'b1 && lat < 400) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({b32.busy, b32.done, b32.err} !== 3'b000 ||
            b32.factorial_out !== 32'd0) begin
            errors++;
            $display("FAIL reset32: got b/d/e=%b%b%b out=%0d want 000 out=0",
                     b32.busy, b32.done, b32.err, b32.factorial_out);
        end
        checks++;
        if ({b64.busy, b64.done, b64.err} !== 3'b000 ||
            b64.factorial_out !== 64'd0) begin
            errors++;
            $display("FAIL reset64: got b/d/e=%b%b%b out=%0d want 000 out=0",
                     b64.busy, b64.done, b64.err, b64.factorial_out);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({b32.busy, b32.done, b32.err} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: got b/d/e=%b%b%b want 000",
                     b32.busy, b32.done, b32.err);
        end
    endtask

    task automatic test_n5();
        int lat;
        bit bok;
        start32(8'd5);
        checks++;
        if (b32.busy !== 1'b1 || b32.done !== 1'b0) begin
            errors++;
            $display("FAIL n5_start: got busy=%b done=%b want 1 0",
                     b32.busy, b32.done);
        end
        wait32(lat, bok);
        checks++;
        if (lat !== 5 || bok !== 1'b1) begin
            errors++;
            $display("FAIL n5_latency: got %0d busy_ok=%b want 5 1",
                     lat, bok);
        end
        checks++;
        if (b32.factorial_out !== 32'd120 || b32.err !== 1'b0 ||
            b32.busy !== 1'b0) begin
            errors++;
            $display("FAIL n5_result: got %0d err=%b busy=%b want 120 0 0",
                     b32.factorial_out, b32.err, b32.busy);
        end
        repeat (3) tick();
        checks++;
        if (b32.done !== 1'b1 || b32.factorial_out !== 32'd120) begin
            errors++;
            $display("FAIL n5_hold: got done=%b out=%0d want 1 120",
                     b32.done, b32.factorial_out);
        end
    endtask

    task automatic test_small();
        logic [7:0]  ns [3]  = '{8'd0, 8'd1, 8'd12};
        logic [31:0] res [3] = '{32'd1, 32'd1, 32'd479001600};
        int          lats [3] = '{1, 1, 12};
        int          lat;
        bit          bok;
        for (int i = 0; i < 3; i++) begin
            start32(ns[i]);
            wait32(lat, bok);
            checks++;
            if (b32.factorial_out !== res[i] || b32.err !== 1'b0) begin
                errors++;
                $display("FAIL small_result n=%0d: got %0d err=%b want %0d 0",
                         ns[i], b32.factorial_out, b32.err, res[i]);
            end
            checks++;
            if (lat !== lats[i] || bok !== 1'b1) begin
                errors++;
                $display("FAIL small_latency n=%0d: got %0d busy_ok=%b want %0d 1",
                         ns[i], lat, bok, lats[i]);
            end
        end
    endtask

    task automatic test_overflow32();
        int lat;
        bit bok;
        start32(8'd13);
        wait32(lat, bok);
        checks++;
        if (lat !== 12) begin
            errors++;
            $display("FAIL ovf13_latency: got %0d want 12", lat);
        end
        checks++;
        if ({b32.busy, b32.done, b32.err} !== 3'b011 ||
            b32.factorial_out !== 32'd0) begin
            errors++;
            $display("FAIL ovf13_state: got b/d/e=%b%b%b out=%0d want 011 0",
                     b32.busy, b32.done, b32.err, b32.factorial_out);
        end
        start32(8'd4);
        checks++;
        if ({b32.busy, b32.done, b32.err} !== 3'b100) begin
            errors++;
            $display("FAIL err_clear: got b/d/e=%b%b%b want 100",
                     b32.busy, b32.done, b32.err);
        end
        wait32(lat, bok);
        checks++;
        if (b32.factorial_out !== 32'd24 || b32.err !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL after_err n=4: got %0d err=%b lat=%0d want 24 0 4",
                     b32.factorial_out, b32.err, lat);
        end
    endtask

    task automatic test_wide64();
        int lat;
        start64(8'd20);
        wait64(lat);
        checks++;
        if (b64.factorial_out !== 64'd2432902008176640000 ||
            b64.err !== 1'b0 || lat !== 20) begin
            errors++;
            $display("FAIL w64_n20: got %0d err=%b lat=%0d want 2432902008176640000 0 20",
                     b64.factorial_out, b64.err, lat);
        end
        // 21*20*...*3 = 21!/2 is the first partial above 2^64-1
        start64(8'd21);
        wait64(lat);
        checks++;
        if (b64.err !== 1'b1 || b64.factorial_out !== 64'd0 || lat !== 19) begin
            errors++;
            $display("FAIL w64_n21: got err=%b out=%0d lat=%0d want 1 0 19",
                     b64.err, b64.factorial_out, lat);
        end
        start64(8'd255);
        wait64(lat);
        checks++;
        if (b64.err !== 1'b1 || b64.done !== 1'b1) begin
            errors++;
            $display("FAIL w64_n255: got err=%b done=%b want 1 1",
                     b64.err, b64.done);
        end
        checks++;
        if ($isunknown({b64.busy, b64.done, b64.err, b64.factorial_out})) begin
            errors++;
            $display("FAIL w64_n255_x: got out=%h want no X", b64.factorial_out);
        end
    endtask

    task automatic test_n_change();
        int lat;
        bit bok;
        start32(8'd6);
        tick();
        b32.n  = 8'd3;
        b32.go = 1'b1;
        tick();
        b32.go = 1'b0;
        wait32(lat, bok);
        checks++;
        if (b32.factorial_out !== 32'd720 || lat + 2 !== 6 || bok !== 1'b1) begin
            errors++;
            $display("FAIL n_change: got %0d lat=%0d busy_ok=%b want 720 6 1",
                     b32.factorial_out, lat + 2, bok);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bok;
        b32.n  = 8'd3;
        b32.go = 1'b1;
        tick();
        wait32(lat, bok);
        checks++;
        if (b32.factorial_out !== 32'd6 || lat !== 3) begin
            errors++;
            $display("FAIL b2b_first: got %0d lat=%0d want 6 3",
                     b32.factorial_out, lat);
        end
        tick();
        checks++;
        if ({b32.busy, b32.done, b32.err} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_restart: got b/d/e=%b%b%b want 100",
                     b32.busy, b32.done, b32.err);
        end
        b32.n = 8'd7;
        wait32(lat, bok);
        b32.go = 1'b0;
        checks++;
        if (b32.factorial_out !== 32'd6 || lat !== 3) begin
            errors++;
            $display("FAIL b2b_second: got %0d lat=%0d want 6 3",
                     b32.factorial_out, lat);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        bit bok;
        start32(8'd6);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({b32.busy, b32.done, b32.err} !== 3'b000 ||
            b32.factorial_out !== 32'd0) begin
            errors++;
            $display("FAIL async_rst: got b/d/e=%b%b%b out=%0d want 000 0",
                     b32.busy, b32.done, b32.err, b32.factorial_out);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (b32.busy !== 1'b0 || b32.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_resume: got busy=%b done=%b want 0 0",
                     b32.busy, b32.done);
        end
        start32(8'd3);
        wait32(lat, bok);
        checks++;
        if (b32.factorial_out !== 32'd6 || lat !== 3 || b32.err !== 1'b0) begin
            errors++;
            $display("FAIL post_rst n=3: got %0d lat=%0d err=%b want 6 3 0",
                     b32.factorial_out, lat, b32.err);
        end
    endtask

    initial begin
        b32.n  = '0;
        b32.go = 1'b0;
        b64.n  = '0;
        b64.go = 1'b0;
        test_reset();
        test_n5();
        test_small();
        test_overflow32();
        test_wide64();
        test_n_change();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
